// File: rtl/lia_result_snapshot_if.sv
// Snapshot handshake bundle between the processor PIOs (master) and the
// lock-in result snapshot block (slave).
interface lia_result_snapshot_if #(
   parameter int OUT_W = 16,
   parameter int SEL_W = 3
);
   logic [SEL_W-1:0] sel;
   logic             snap_req;
   logic             snap_ack;
   logic [OUT_W-1:0] lia_x_export;
   logic [OUT_W-1:0] lia_y_export;
   logic             snap_fresh;

   modport master (
      output sel, snap_req,
      input  snap_ack, lia_x_export, lia_y_export, snap_fresh
   );

   modport slave (
      input  sel, snap_req,
      output snap_ack, lia_x_export, lia_y_export, snap_fresh
   );
endinterface

// File: rtl/lia_result_snapshot.sv
// Lock-in return path: block-averages per-channel X/Y results and hands one
// coherent X/Y pair to the processor under a 4-phase req/ack handshake.
module lia_result_snapshot #(
   parameter int NCH      = 8,
   parameter int IN_W     = 24,
   parameter int OUT_W    = 16,
   parameter int AVG_LOG2 = 4
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic [NCH-1:0]      in_valid,
   input  logic [NCH*IN_W-1:0] in_x,
   input  logic [NCH*IN_W-1:0] in_y,
   input  logic                ovf_clr,
   output logic [NCH-1:0]      ovf_flags,
   lia_result_snapshot_if.slave snap
);
   localparam int ACC_W = IN_W + AVG_LOG2 + 1;
   localparam int S     = AVG_LOG2 + IN_W - OUT_W;
   localparam int SEL_W = 3;
   localparam logic signed [ACC_W-1:0] RND  = ACC_W'(64'sd1 << (S - 1));
   localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((64'sd1 << (OUT_W - 1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-(64'sd1 << (OUT_W - 1)));

   typedef enum logic [1:0] {IDLE, CAPTURE, ACK} state_t;

   logic signed [ACC_W-1:0] accX_q [NCH];
   logic signed [ACC_W-1:0] accX_d [NCH];
   logic signed [ACC_W-1:0] accY_q [NCH];
   logic signed [ACC_W-1:0] accY_d [NCH];
   logic [AVG_LOG2-1:0]     cnt_q  [NCH];
   logic [AVG_LOG2-1:0]     cnt_d  [NCH];
   logic [OUT_W-1:0]        resX_q [NCH];
   logic [OUT_W-1:0]        resX_d [NCH];
   logic [OUT_W-1:0]        resY_q [NCH];
   logic [OUT_W-1:0]        resY_d [NCH];
   logic [NCH-1:0]          fresh_q, fresh_d;
   logic [NCH-1:0]          ovf_q, ovf_d;

   state_t           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             ack_q, ack_d;
   logic [OUT_W-1:0] liaX_q, liaX_d;
   logic [OUT_W-1:0] liaY_q, liaY_d;
   logic             snapFresh_q, snapFresh_d;

   // Round half up by adding half an LSB before the arithmetic shift, then clamp.
   function automatic logic [OUT_W-1:0] roundSat(input logic signed [ACC_W-1:0] sum,
                                                 output logic sat);
      logic signed [ACC_W-1:0] r;
      r   = (sum + RND) >>> S;
      sat = 1'b0;
      if (r > MAXV) begin
         sat      = 1'b1;
         roundSat = MAXV[OUT_W-1:0];
      end else if (r < MINV) begin
         sat      = 1'b1;
         roundSat = MINV[OUT_W-1:0];
      end else begin
         roundSat = r[OUT_W-1:0];
      end
   endfunction

   // Per-channel accumulation; a completed block writes X and Y together and
   // its fresh/ovf set takes priority over a same-edge capture clear or ovf_clr.
   always_comb begin
      logic signed [IN_W-1:0]  sampX, sampY;
      logic signed [ACC_W-1:0] sumX, sumY;
      logic                    satX, satY;
      ovf_d   = ovf_clr ? '0 : ovf_q;
      fresh_d = fresh_q;
      if (state_q == CAPTURE) fresh_d[sel_q] = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         accX_d[i] = accX_q[i];
         accY_d[i] = accY_q[i];
         cnt_d[i]  = cnt_q[i];
         resX_d[i] = resX_q[i];
         resY_d[i] = resY_q[i];
         sampX     = signed'(in_x[i*IN_W +: IN_W]);
         sampY     = signed'(in_y[i*IN_W +: IN_W]);
         sumX      = accX_q[i] + ACC_W'(sampX);
         sumY      = accY_q[i] + ACC_W'(sampY);
         satX      = 1'b0;
         satY      = 1'b0;
         if (in_valid[i]) begin
            if (cnt_q[i] == '1) begin
               resX_d[i]  = roundSat(sumX, satX);
               resY_d[i]  = roundSat(sumY, satY);
               accX_d[i]  = '0;
               accY_d[i]  = '0;
               cnt_d[i]   = '0;
               fresh_d[i] = 1'b1;
               if (satX || satY) ovf_d[i] = 1'b1;
            end else begin
               accX_d[i] = sumX;
               accY_d[i] = sumY;
               cnt_d[i]  = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Snapshot FSM; outputs only move in CAPTURE so the PIO sees stable data in ACK.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      ack_d       = ack_q;
      liaX_d      = liaX_q;
      liaY_d      = liaY_q;
      snapFresh_d = snapFresh_q;
      case (state_q)
         IDLE: begin
            if (snap.snap_req) begin
               sel_d   = (int'(snap.sel) >= NCH) ? SEL_W'(NCH - 1) : snap.sel;
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            liaX_d      = resX_q[sel_q];
            liaY_d      = resY_q[sel_q];
            snapFresh_d = fresh_q[sel_q];
            ack_d       = 1'b1;
            state_d     = ACK;
         end
         ACK: begin
            if (!snap.snap_req) begin
               ack_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // All state registers share one synchronous active-low reset.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         for (int i = 0; i < NCH; i++) begin
            accX_q[i] <= '0;
            accY_q[i] <= '0;
            cnt_q[i]  <= '0;
            resX_q[i] <= '0;
            resY_q[i] <= '0;
         end
         fresh_q     <= '0;
         ovf_q       <= '0;
         state_q     <= IDLE;
         sel_q       <= '0;
         ack_q       <= 1'b0;
         liaX_q      <= '0;
         liaY_q      <= '0;
         snapFresh_q <= 1'b0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            accX_q[i] <= accX_d[i];
            accY_q[i] <= accY_d[i];
            cnt_q[i]  <= cnt_d[i];
            resX_q[i] <= resX_d[i];
            resY_q[i] <= resY_d[i];
         end
         fresh_q     <= fresh_d;
         ovf_q       <= ovf_d;
         state_q     <= state_d;
         sel_q       <= sel_d;
         ack_q       <= ack_d;
         liaX_q      <= liaX_d;
         liaY_q      <= liaY_d;
         snapFresh_q <= snapFresh_d;
      end
   end

   assign ovf_flags         = ovf_q;
   assign snap.snap_ack     = ack_q;
   assign snap.lia_x_export = liaX_q;
   assign snap.lia_y_export = liaY_q;
   assign snap.snap_fresh   = snapFresh_q;
endmodule

// File: tb/tb_lia_result_snapshot.sv
// Self-checking bench for lia_result_snapshot: a behavioural averaging model
// predicts each snapshot, expectations are queued at request and popped at ack.
module tb_lia_result_snapshot;
   localparam int NCH = 8, IN_W = 24, OUT_W = 16, AVG_LOG2 = 4;

   logic                clk = 1'b0;
   logic                rstN = 1'b0;
   logic [NCH-1:0]      inValid = '0;
   logic [NCH*IN_W-1:0] inX = '0;
   logic [NCH*IN_W-1:0] inY = '0;
   logic                ovfClr = 1'b0;
   logic [NCH-1:0]      ovfFlags;

   lia_result_snapshot_if #(.OUT_W(OUT_W), .SEL_W(3)) snapIf ();

   lia_result_snapshot #(.NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W), .AVG_LOG2(AVG_LOG2)) dut (
      .clk_clk       (clk),
      .reset_reset_n (rstN),
      .in_valid      (inValid),
      .in_x          (inX),
      .in_y          (inY),
      .ovf_clr       (ovfClr),
      .ovf_flags     (ovfFlags),
      .snap          (snapIf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      logic        fresh;
   } snapExp_t;

   snapExp_t       scoreboard[$];
   longint         mSumX[NCH];
   longint         mSumY[NCH];
   int             mCnt[NCH];
   logic [15:0]    mResX[NCH];
   logic [15:0]    mResY[NCH];
   logic [NCH-1:0] mFresh;
   logic [NCH-1:0] mOvf;
   int             checkCount = 0;
   int             passCount = 0;

   // Average of 16 samples scaled from 24 to 16 bits: divide by 2^12, round half up.
   function automatic logic [15:0] modelRound(input longint sum, output logic sat);
      longint r;
      r   = (sum + 64'sd2048) >>> 12;
      sat = 1'b0;
      if (r > 64'sd32767) begin
         sat = 1'b1;
         r   = 64'sd32767;
      end else if (r < -64'sd32768) begin
         sat = 1'b1;
         r   = -64'sd32768;
      end
      return r[15:0];
   endfunction

   task automatic modelReset();
      for (int i = 0; i < NCH; i++) begin
         mSumX[i] = 0;
         mSumY[i] = 0;
         mCnt[i]  = 0;
         mResX[i] = '0;
         mResY[i] = '0;
      end
      mFresh = '0;
      mOvf   = '0;
      scoreboard.delete();
   endtask

   task automatic modelApply(input int ch, input logic [23:0] x, input logic [23:0] y);
      logic satX, satY;
      mSumX[ch] += longint'(signed'(x));
      mSumY[ch] += longint'(signed'(y));
      mCnt[ch]++;
      if (mCnt[ch] == 16) begin
         mResX[ch]  = modelRound(mSumX[ch], satX);
         mResY[ch]  = modelRound(mSumY[ch], satY);
         mFresh[ch] = 1'b1;
         if (satX || satY) mOvf[ch] = 1'b1;
         mSumX[ch] = 0;
         mSumY[ch] = 0;
         mCnt[ch]  = 0;
      end
   endtask

   // One valid sample on one channel, driven for exactly one edge.
   task automatic feed(input int ch, input logic [23:0] x, input logic [23:0] y);
      inValid                  = '0;
      inValid[ch]              = 1'b1;
      inX[ch*IN_W +: IN_W]     = x;
      inY[ch*IN_W +: IN_W]     = y;
      @(posedge clk);
      #1;
      inValid = '0;
      modelApply(ch, x, y);
   endtask

   task automatic feedBlock(input int ch, input logic [23:0] x, input logic [23:0] y, input int n);
      repeat (n) feed(ch, x, y);
   endtask

   // Full handshake: latency, captured pair, no retrigger while req held, release.
   task automatic doSnapshot(input logic [2:0] selV, input string name);
      int       cycles;
      snapExp_t e;
      snapIf.sel      = selV;
      snapIf.snap_req = 1'b1;
      e.x     = mResX[selV];
      e.y     = mResY[selV];
      e.fresh = mFresh[selV];
      scoreboard.push_back(e);
      mFresh[selV] = 1'b0;
      cycles = 0;
      do begin
         @(posedge clk);
         #1;
         cycles++;
      end while (!snapIf.snap_ack && cycles < 8);
      checkCount++;
      if (cycles !== 2) $display("[TB] FAIL %s ack_latency: got %0d edges expected 2", name, cycles);
      else passCount++;
      e = scoreboard.pop_front();
      checkCount++;
      if (snapIf.lia_x_export !== e.x) $display("[TB] FAIL %s x: got %h expected %h", name, snapIf.lia_x_export, e.x);
      else passCount++;
      checkCount++;
      if (snapIf.lia_y_export !== e.y) $display("[TB] FAIL %s y: got %h expected %h", name, snapIf.lia_y_export, e.y);
      else passCount++;
      checkCount++;
      if (snapIf.snap_fresh !== e.fresh) $display("[TB] FAIL %s fresh: got %b expected %b", name, snapIf.snap_fresh, e.fresh);
      else passCount++;
      repeat (3) @(posedge clk);
      #1;
      checkCount++;
      if (snapIf.snap_ack !== 1'b1 || snapIf.lia_x_export !== e.x)
         $display("[TB] FAIL %s ack_hold: got ack=%b x=%h expected ack=1 x=%h", name, snapIf.snap_ack, snapIf.lia_x_export, e.x);
      else passCount++;
      snapIf.snap_req = 1'b0;
      @(posedge clk);
      #1;
      checkCount++;
      if (snapIf.snap_ack !== 1'b0 || snapIf.lia_y_export !== e.y)
         $display("[TB] FAIL %s ack_release: got ack=%b y=%h expected ack=0 y=%h", name, snapIf.snap_ack, snapIf.lia_y_export, e.y);
      else passCount++;
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkCount++;
      if ({snapIf.snap_ack, snapIf.snap_fresh} !== 2'b00)
         $display("[TB] FAIL reset_ack_fresh: got %b expected 00", {snapIf.snap_ack, snapIf.snap_fresh});
      else passCount++;
      checkCount++;
      if ({snapIf.lia_x_export, snapIf.lia_y_export} !== 32'h0)
         $display("[TB] FAIL reset_data: got %h expected 00000000", {snapIf.lia_x_export, snapIf.lia_y_export});
      else passCount++;
      checkCount++;
      if (ovfFlags !== 8'h00) $display("[TB] FAIL reset_ovf: got %h expected 00", ovfFlags);
      else passCount++;
      rstN = 1'b1;
      modelReset();
   endtask

   task automatic test_basic();
      feedBlock(0, 24'h001000, 24'hFFF000, 16);
      doSnapshot(3'd0, "basic_ch0");
      checkCount++;
      if ({snapIf.lia_x_export, snapIf.lia_y_export} !== 32'h0010FFF0)
         $display("[TB] FAIL basic_const: got %h expected 0010fff0", {snapIf.lia_x_export, snapIf.lia_y_export});
      else passCount++;
      doSnapshot(3'd0, "stale_ch0");
   endtask

   task automatic test_saturation();
      feedBlock(3, 24'h7FFFFF, 24'h000000, 16);
      checkCount++;
      if (ovfFlags !== 8'h08) $display("[TB] FAIL sat_ovf: got %h expected 08", ovfFlags);
      else passCount++;
      doSnapshot(3'd3, "sat_ch3");
      checkCount++;
      if (snapIf.lia_x_export !== 16'h7FFF) $display("[TB] FAIL sat_const: got %h expected 7fff", snapIf.lia_x_export);
      else passCount++;
      ovfClr = 1'b1;
      @(posedge clk);
      #1;
      ovfClr = 1'b0;
      mOvf   = '0;
      checkCount++;
      if (ovfFlags !== mOvf) $display("[TB] FAIL ovf_clear: got %h expected %h", ovfFlags, mOvf);
      else passCount++;
      feedBlock(3, 24'h7FFFFF, 24'h000000, 15);
      ovfClr = 1'b1;
      mOvf   = '0;
      feed(3, 24'h7FFFFF, 24'h000000);
      ovfClr = 1'b0;
      checkCount++;
      if (ovfFlags !== 8'h08) $display("[TB] FAIL ovf_set_wins: got %h expected 08", ovfFlags);
      else passCount++;
   endtask

   task automatic test_rounding();
      feedBlock(1, 24'd2048, 24'd0, 16);
      doSnapshot(3'd1, "round_2048");
      checkCount++;
      if (snapIf.lia_x_export !== 16'h0008) $display("[TB] FAIL round_2048_const: got %h expected 0008", snapIf.lia_x_export);
      else passCount++;
      for (int k = 0; k < 16; k++) feed(1, (k % 2 == 0) ? 24'd0 : 24'd6144, 24'd0);
      doSnapshot(3'd1, "round_half");
      checkCount++;
      if (snapIf.lia_x_export !== 16'h000C) $display("[TB] FAIL round_half_const: got %h expected 000c", snapIf.lia_x_export);
      else passCount++;
   endtask

   // Block completion on ch2 lands on the very edge that captures ch2.
   task automatic test_collision();
      snapExp_t e;
      feedBlock(2, 24'h002000, 24'h000800, 16);
      feedBlock(2, 24'h003000, 24'h000000, 15);
      snapIf.sel      = 3'd2;
      snapIf.snap_req = 1'b1;
      e.x     = mResX[2];
      e.y     = mResY[2];
      e.fresh = mFresh[2];
      scoreboard.push_back(e);
      mFresh[2] = 1'b0;
      @(posedge clk);
      #1;
      feed(2, 24'h003000, 24'h000000);
      e = scoreboard.pop_front();
      checkCount++;
      if (snapIf.snap_ack !== 1'b1) $display("[TB] FAIL collide_ack: got %b expected 1", snapIf.snap_ack);
      else passCount++;
      checkCount++;
      if ({snapIf.lia_x_export, snapIf.lia_y_export, snapIf.snap_fresh} !== {e.x, e.y, e.fresh})
         $display("[TB] FAIL collide_old_pair: got %h expected %h",
                  {snapIf.lia_x_export, snapIf.lia_y_export, snapIf.snap_fresh}, {e.x, e.y, e.fresh});
      else passCount++;
      snapIf.snap_req = 1'b0;
      @(posedge clk);
      #1;
      doSnapshot(3'd2, "collide_new_pair");
      checkCount++;
      if ({snapIf.lia_x_export, snapIf.snap_fresh} !== {16'h0030, 1'b1})
         $display("[TB] FAIL collide_new_const: got %h expected 00301", {snapIf.lia_x_export, snapIf.snap_fresh});
      else passCount++;
   endtask

   task automatic test_reset_mid();
      int cycles;
      feedBlock(5, 24'h001000, 24'h002000, 5);
      snapIf.sel      = 3'd0;
      snapIf.snap_req = 1'b1;
      cycles = 0;
      do begin
         @(posedge clk);
         #1;
         cycles++;
      end while (!snapIf.snap_ack && cycles < 8);
      checkCount++;
      if (snapIf.snap_ack !== 1'b1) $display("[TB] FAIL midreset_reach_ack: got %b expected 1", snapIf.snap_ack);
      else passCount++;
      rstN            = 1'b0;
      snapIf.snap_req = 1'b0;
      @(posedge clk);
      #1;
      checkCount++;
      if ({snapIf.snap_ack, snapIf.snap_fresh, snapIf.lia_x_export, snapIf.lia_y_export} !== 34'h0)
         $display("[TB] FAIL midreset_outputs: got %h expected 0",
                  {snapIf.snap_ack, snapIf.snap_fresh, snapIf.lia_x_export, snapIf.lia_y_export});
      else passCount++;
      rstN = 1'b1;
      modelReset();
      feedBlock(5, 24'h001000, 24'h002000, 15);
      doSnapshot(3'd5, "midreset_partial");
      feed(5, 24'h001000, 24'h002000);
      doSnapshot(3'd5, "midreset_full");
   endtask

   initial begin
      snapIf.sel      = '0;
      snapIf.snap_req = 1'b0;
      modelReset();
      @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_saturation();
      test_rounding();
      test_collision();
      test_reset_mid();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
